// File: rtl/sdu_pkg.sv
// sdu_pkg: shared definitions for the SDUltrasound sequencer paths (state encoding,
// default widths, sign-extension helper used by both TX and RX).
package sdu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } sdu_state_e;

  localparam int SDU_AWIDTH     = 12;
  localparam int SDU_DWIDTH     = 16;
  localparam int SDU_ACC_WIDTH  = 24;
  localparam int SDU_PASS_WIDTH = 8;

  // Callers size the result down with a cast, so one helper serves every width pair.
  function automatic logic [63:0] sign_extend(input logic [63:0] value, input int from_width);
    logic [63:0] mask;
    mask = ~64'd0 << from_width;
    return value[from_width-1] ? (value | mask) : (value & ~mask);
  endfunction

endpackage

// File: rtl/sdu_rx_ram.sv
// sdu_rx_ram: simple dual-port inferred RAM, one write port and one registered read port
// (read data valid the cycle after the read enable).
module sdu_rx_ram #(
  parameter int AWIDTH = 12,
  parameter int WIDTH  = 24
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sdu_rx_capture.sv
// sdu_rx_capture: records one TX-sequence window of ADC samples into RAM and plays it back
// to the PC one word per strobe. Define SDU_RX_AVG_EN for coherent averaging across passes.
module sdu_rx_capture
  import sdu_pkg::*;
#(
  parameter int AWIDTH    = SDU_AWIDTH,
  parameter int DWIDTH    = SDU_DWIDTH,
  parameter int ACC_WIDTH = SDU_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sdu_rx_en,
  input  logic                 sdu_seq_done_strobe,
  input  logic [DWIDTH-1:0]    adc_in,
  input  logic                 rd_strobe,
  input  logic                 rd_restart,
  input  logic                 avg_clear,
  output logic [ACC_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 capture_done,
  output logic [AWIDTH:0]      capture_len,
  output logic                 overflow,
  output logic [7:0]           pass_count
);

  localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};

  sdu_state_e state, state_next;

  logic                 rx_en_q;
  logic                 rx_rise;
  logic [AWIDTH:0]      wr_idx;
  logic [AWIDTH:0]      rd_idx;
  logic [AWIDTH:0]      rd_next;
  logic [AWIDTH:0]      wr_limit;
  logic                 store;
  logic                 rd_issue;
  logic                 rd_rewind;
  logic                 rd_zero_q;
  logic                 wr_pend;
  logic [AWIDTH-1:0]    wr_addr_q;
  logic [DWIDTH-1:0]    adc_q;
  logic [ACC_WIDTH-1:0] sample_ext;
  logic [ACC_WIDTH-1:0] wr_data;
  logic [ACC_WIDTH-1:0] ram_rdata;

  assign rx_rise    = sdu_rx_en & ~rx_en_q;
  assign rd_next    = rd_idx + 1'b1;
  assign sample_ext = ACC_WIDTH'(sign_extend(64'(adc_q), DWIDTH));

`ifdef SDU_RX_AVG_EN
  logic accumulate;
  logic acc_q;

  // Later passes are clipped to the pass-0 record length so every word gets the same pass count.
  assign accumulate = (pass_count != 8'd0);
  assign wr_limit   = accumulate ? capture_len : DEPTH;

  always_comb begin
    wr_data = sample_ext;
    if (acc_q) wr_data = ram_rdata + sample_ext;
  end
`else
  logic unused_avg_clear;

  assign unused_avg_clear = avg_clear;
  assign wr_limit         = DEPTH;

  always_comb begin
    wr_data = sample_ext;
  end
`endif

  always_comb begin
    state_next = state;
    store      = 1'b0;
    rd_issue   = 1'b0;
    rd_rewind  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_rise) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (sdu_seq_done_strobe || !sdu_rx_en || (wr_idx >= wr_limit)) begin
          state_next = ST_FLUSH;
        end else begin
          store = 1'b1;
          if (wr_idx == wr_limit - 1'b1) state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (rx_rise) state_next = ST_CAPTURE;
        else if (rd_restart) rd_rewind = 1'b1;
        else if (rd_strobe) rd_issue = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Writes trail their sample by one cycle; FLUSH gives the final write time to land.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      rx_en_q      <= 1'b0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      wr_pend      <= 1'b0;
      wr_addr_q    <= '0;
      adc_q        <= '0;
      rd_valid     <= 1'b0;
      rd_zero_q    <= 1'b0;
      capture_done <= 1'b0;
      capture_len  <= '0;
      overflow     <= 1'b0;
      pass_count   <= '0;
`ifdef SDU_RX_AVG_EN
      acc_q        <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      rx_en_q   <= sdu_rx_en;
      wr_pend   <= store;
      rd_valid  <= rd_issue;
      rd_zero_q <= rd_issue && (capture_len == '0);

      if (store) begin
        wr_addr_q <= wr_idx[AWIDTH-1:0];
        adc_q     <= adc_in;
        wr_idx    <= wr_idx + 1'b1;
`ifdef SDU_RX_AVG_EN
        acc_q     <= accumulate;
`endif
        if (wr_idx == DEPTH - 1'b1) overflow <= 1'b1;
      end

      if ((state != ST_CAPTURE) && (state_next == ST_CAPTURE)) begin
        capture_done <= 1'b0;
        overflow     <= 1'b0;
        wr_idx       <= '0;
        rd_idx       <= '0;
      end

      if (rd_rewind) rd_idx <= '0;
      else if (rd_issue) rd_idx <= (rd_next >= capture_len) ? '0 : rd_next;

      if (state == ST_FLUSH) begin
        capture_done <= 1'b1;
        if (pass_count != 8'hFF) pass_count <= pass_count + 8'd1;
`ifdef SDU_RX_AVG_EN
        if (pass_count == 8'd0) capture_len <= wr_idx;
`else
        capture_len <= wr_idx;
`endif
      end

`ifdef SDU_RX_AVG_EN
      if (avg_clear && ((state == ST_IDLE) || (state == ST_DONE))) pass_count <= '0;
`endif
    end
  end

  // A zero-length record still answers a read, with zero data.
  assign rd_data = (rd_valid && !rd_zero_q) ? ram_rdata : '0;

  sdu_rx_ram #(
    .AWIDTH(AWIDTH),
    .WIDTH (ACC_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_pend),
    .waddr(wr_addr_q),
    .wdata(wr_data),
    .re   (rd_issue | store),
    .raddr(rd_issue ? rd_idx[AWIDTH-1:0] : wr_idx[AWIDTH-1:0]),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_sdu_rx_capture.sv
// tb_sdu_rx_capture: directed checks of capture, readout, overflow, zero-length,
// reset abort and (with SDU_RX_AVG_EN) coherent averaging.
`timescale 1ns/1ps
module tb_sdu_rx_capture;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int ACCW  = 24;
  localparam int DEPTH = 2**AW;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            sdu_rx_en;
  logic            sdu_seq_done_strobe;
  logic [DW-1:0]   adc_in;
  logic            rd_strobe;
  logic            rd_restart;
  logic            avg_clear;
  logic [ACCW-1:0] rd_data;
  logic            rd_valid;
  logic            capture_done;
  logic [AW:0]     capture_len;
  logic            overflow;
  logic [7:0]      pass_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic            rd_strobe;
    logic            rd_restart;
    logic            exp_valid;
    logic [ACCW-1:0] exp_data;
  } read_vec_t;

  read_vec_t read_vecs[19];

  always #5 clk = ~clk;

  sdu_rx_capture #(
    .AWIDTH   (AW),
    .DWIDTH   (DW),
    .ACC_WIDTH(ACCW)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .sdu_rx_en          (sdu_rx_en),
    .sdu_seq_done_strobe(sdu_seq_done_strobe),
    .adc_in             (adc_in),
    .rd_strobe          (rd_strobe),
    .rd_restart         (rd_restart),
    .avg_clear          (avg_clear),
    .rd_data            (rd_data),
    .rd_valid           (rd_valid),
    .capture_done       (capture_done),
    .capture_len        (capture_len),
    .overflow           (overflow),
    .pass_count         (pass_count)
  );

  // Inputs are held across one rising edge; outputs are then sampled 1ns after it.
  task automatic applyStimulus(input logic en, input logic done, input logic [DW-1:0] adc,
                               input logic rds, input logic rdr, input logic clr);
    sdu_rx_en           = en;
    sdu_seq_done_strobe = done;
    adc_in              = adc;
    rd_strobe           = rds;
    rd_restart          = rdr;
    avg_clear           = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " rd_data"}, 32'(rd_data), 32'd0);
    checkOutput({tag, " rd_valid"}, 32'(rd_valid), 32'd0);
    checkOutput({tag, " capture_done"}, 32'(capture_done), 32'd0);
    checkOutput({tag, " capture_len"}, 32'(capture_len), 32'd0);
    checkOutput({tag, " overflow"}, 32'(overflow), 32'd0);
    checkOutput({tag, " pass_count"}, 32'(pass_count), 32'd0);
  endtask

  task automatic readWord(input string name, input logic [ACCW-1:0] expected);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput({name, " valid"}, 32'(rd_valid), 32'd1);
    checkOutput({name, " data"}, 32'(rd_data), 32'(expected));
  endtask

  task automatic checkRecord(input string tag, input int len, input logic ovf, input int passes);
    checkOutput({tag, " capture_done"}, 32'(capture_done), 32'd1);
    checkOutput({tag, " capture_len"}, 32'(capture_len), 32'(len));
    checkOutput({tag, " overflow"}, 32'(overflow), 32'(ovf));
    checkOutput({tag, " pass_count"}, 32'(pass_count), 32'(passes));
  endtask

  initial begin
    for (int i = 0; i < 10; i++) read_vecs[i] = '{1'b1, 1'b0, 1'b1, 24'(i)};
    read_vecs[10] = '{1'b1, 1'b0, 1'b1, 24'd0};
    read_vecs[11] = '{1'b0, 1'b0, 1'b0, 24'd0};
    read_vecs[12] = '{1'b1, 1'b0, 1'b1, 24'd1};
    read_vecs[13] = '{1'b1, 1'b0, 1'b1, 24'd2};
    read_vecs[14] = '{1'b1, 1'b1, 1'b0, 24'd0};
    read_vecs[15] = '{1'b1, 1'b0, 1'b1, 24'd0};
    read_vecs[16] = '{1'b1, 1'b0, 1'b1, 24'd1};
    read_vecs[17] = '{1'b0, 1'b1, 1'b0, 24'd0};
    read_vecs[18] = '{1'b1, 1'b0, 1'b1, 24'd0};

    reset_n = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkAllZero("reset");
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("[TB] ramp capture of 10 samples");
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, DW'(i), (i == 3), 1'b0, 1'b0);
      if (i == 3) checkOutput("rd_strobe in capture", 32'(rd_valid), 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 16'd99, 1'b0, 1'b0, 1'b0);
    checkOutput("done before flush", 32'(capture_done), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkRecord("ramp", 10, 1'b0, 1);
    for (int v = 0; v < 19; v++) begin
      applyStimulus(1'b0, 1'b0, '0, read_vecs[v].rd_strobe, read_vecs[v].rd_restart, 1'b0);
      checkOutput($sformatf("vec%0d valid", v), 32'(rd_valid), 32'(read_vecs[v].exp_valid));
      checkOutput($sformatf("vec%0d data", v), 32'(rd_data), 32'(read_vecs[v].exp_data));
    end

    $display("[TB] overflow window");
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("restart clears done", 32'(capture_done), 32'd0);
    for (int i = 0; i < DEPTH + 5; i++) applyStimulus(1'b1, 1'b0, DW'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
`ifdef SDU_RX_AVG_EN
    checkRecord("overflow", DEPTH, 1'b1, 1);
`else
    checkRecord("overflow", DEPTH, 1'b1, 2);
`endif
    for (int i = 0; i < DEPTH; i++) readWord($sformatf("ovf word%0d", i), ACCW'(i));
    readWord("ovf wrap", 24'd0);

    $display("[TB] signed samples, ended by rx_en low");
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("overflow cleared", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'hFFFD, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
`ifdef SDU_RX_AVG_EN
    checkRecord("signed", 3, 1'b0, 1);
`else
    checkRecord("signed", 3, 1'b0, 3);
`endif
    readWord("signed -3", 24'hFFFFFD);
    readWord("signed min", 24'hFF8000);
    readWord("signed max", 24'h007FFF);

    $display("[TB] rise with strobe, then zero-length record");
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("rise+strobe starts", 32'(capture_done), 32'd0);
    applyStimulus(1'b1, 1'b1, 16'd6, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
`ifdef SDU_RX_AVG_EN
    checkRecord("zero len", 0, 1'b0, 1);
`else
    checkRecord("zero len", 0, 1'b0, 4);
`endif
    readWord("zero len read", 24'd0);
    readWord("zero len reread", 24'd0);

    $display("[TB] reset mid-capture");
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'd8, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'd9, 1'b0, 1'b0, 1'b0);
    checkAllZero("abort");
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'd50, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'd51, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'd52, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkRecord("post reset", 2, 1'b0, 1);
    readWord("post reset word0", 24'd50);
    readWord("post reset word1", 24'd51);

`ifdef SDU_RX_AVG_EN
    $display("[TB] averaging passes");
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("avg_clear", 32'(pass_count), 32'd0);
    for (int p = 0; p < 5; p++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < ((p == 4) ? 12 : 8); i++)
        applyStimulus(1'b1, 1'b0, 16'hFFFD, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (p == 3) begin
        checkRecord("avg 4 passes", 8, 1'b0, 4);
        for (int i = 0; i < 8; i++) readWord($sformatf("avg word%0d", i), 24'hFFFFF4);
      end
    end
    checkRecord("avg 5th pass", 8, 1'b0, 5);
    readWord("avg5 word0", 24'hFFFFF1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
